// File: rtl/collision_score.sv
// collision_score: hit detection, game state machine, BCD score and best
// score for the flappy-bird pixel pipeline. Consumes the pipe generator's
// column flags and pass level, drives game_status back to it.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a START press; score still shows last game
//   PLAY   | game running; hits latched per frame, passes scored
//   DYING  | bird falling; counts DYING_FRAMES frame ends, no scoring
//   OVER   | game over shown; best updated on entry; START -> IDLE
module collision_score #(
  parameter int GROUND_Y     = 425,
  parameter int DYING_FRAMES = 30,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        START,
  input  logic        fresh,
  input  logic [8:0]  y,
  input  logic        is_bird,
  input  logic        is_column_up,
  input  logic        is_column_down,
  input  logic        score_out,
  output logic        game_status,
  output logic        game_over,
  output logic [11:0] score,
  output logic [11:0] best
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [8:0]       GROUND_ROW = 9'(GROUND_Y);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(DYING_FRAMES - 1);
  localparam logic [11:0]      SCORE_MAX  = 12'h999;

  state_t           state_q;
  logic             fresh_q;
  logic             start_q;
  logic             pass_q;
  logic             hit_q;
  logic             hit_d;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      score_q;
  logic [11:0]      best_q;
  logic             status_q;
  logic             over_q;

  logic             frame_end;
  logic             start_rise;
  logic             pass_rise;
  logic             hit_now;
  logic             hit_seen;
  logic [11:0]      score_inc;

  assign frame_end  = fresh_q & ~fresh;
  assign start_rise = START & ~start_q;
  assign pass_rise  = score_out & ~pass_q;

  // Collision of the bird with either pipe or with the ground, this pixel.
  assign hit_now  = (state_q == S_PLAY) & is_bird &
                    (is_column_up | is_column_down | (y >= GROUND_ROW));
  // A hit on the frame_end cycle itself still belongs to the ending frame.
  assign hit_seen = hit_q | hit_now;

  // Hit latch: accumulates within a frame, cleared after frame_end sampled it.
  always_comb begin
    hit_d = hit_q | hit_now;
    if (frame_end || state_q != S_PLAY) begin
      hit_d = 1'b0;
    end
  end

  // BCD increment with saturation at 999.
  always_comb begin
    score_inc = score_q;
    if (score_q != SCORE_MAX) begin
      if (score_q[3:0] == 4'd9) begin
        score_inc[3:0] = 4'd0;
        if (score_q[7:4] == 4'd9) begin
          score_inc[7:4]  = 4'd0;
          score_inc[11:8] = score_q[11:8] + 4'd1;
        end else begin
          score_inc[7:4] = score_q[7:4] + 4'd1;
        end
      end else begin
        score_inc[3:0] = score_q[3:0] + 4'd1;
      end
    end
  end

  // Edge-detect history and the per-frame hit latch.
  always_ff @(posedge clk) begin
    if (RESET) begin
      fresh_q <= 1'b0;
      start_q <= 1'b0;
      pass_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      fresh_q <= fresh;
      start_q <= START;
      pass_q  <= score_out;
      hit_q   <= hit_d;
    end
  end

  // Game FSM with registered outputs, score, dying counter and best score.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      status_q <= 1'b0;
      over_q   <= 1'b0;
      cnt_q    <= '0;
      score_q  <= '0;
      best_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_q  <= S_PLAY;
            status_q <= 1'b1;
            score_q  <= '0;
          end
        end
        S_PLAY: begin
          if (pass_rise) begin
            score_q <= score_inc;
          end
          if (frame_end && hit_seen) begin
            state_q  <= S_DYING;
            status_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        S_DYING: begin
          if (frame_end) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_FRAME) begin
              state_q <= S_OVER;
              over_q  <= 1'b1;
              // Digits are 0..9, so a plain binary compare orders BCD correctly.
              if (score_q > best_q) begin
                best_q <= score_q;
              end
            end
          end
        end
        S_OVER: begin
          if (start_rise) begin
            state_q <= S_IDLE;
            over_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          status_q <= 1'b0;
          over_q   <= 1'b0;
        end
      endcase
    end
  end

  assign game_status = status_q;
  assign game_over   = over_q;
  assign score       = score_q;
  assign best        = best_q;

endmodule

// File: tb/tb_collision_score.sv
// Testbench for collision_score: directed game scenarios plus randomized
// frames, every cycle compared against an integer-level game model.
module tb_collision_score;

  logic        clk = 1'b0;
  logic        RESET, START, fresh, is_bird, is_column_up, is_column_down, score_out;
  logic [8:0]  y;
  logic        game_status, game_over;
  logic [11:0] score, best;

  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 play, 2 dying, 3 over; scores as plain integers
  int m_mode, m_score, m_best, m_frames;
  bit m_hit, m_fresh_q, m_start_q, m_pass_q;

  always #5 clk = ~clk;

  collision_score dut (
    .clk            (clk),
    .RESET          (RESET),
    .START          (START),
    .fresh          (fresh),
    .y              (y),
    .is_bird        (is_bird),
    .is_column_up   (is_column_up),
    .is_column_down (is_column_down),
    .score_out      (score_out),
    .game_status    (game_status),
    .game_over      (game_over),
    .score          (score),
    .best           (best)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit fe, sr, pr, hn;
    if (RESET) begin
      m_mode = 0; m_score = 0; m_best = 0; m_frames = 0; m_hit = 0;
      m_fresh_q = 0; m_start_q = 0; m_pass_q = 0;
      return;
    end
    fe = m_fresh_q && !fresh;
    sr = START && !m_start_q;
    pr = score_out && !m_pass_q;
    hn = is_bird && (is_column_up || is_column_down || y >= 425);
    case (m_mode)
      0: if (sr) begin m_mode = 1; m_score = 0; end
      1: begin
        if (pr && m_score < 999) m_score++;
        if (hn) m_hit = 1;
        if (fe) begin
          if (m_hit) begin m_mode = 2; m_frames = 0; end
          m_hit = 0;
        end
      end
      2: if (fe) begin
        m_frames++;
        if (m_frames == 30) begin
          m_mode = 3;
          if (m_score > m_best) m_best = m_score;
        end
      end
      default: if (sr) m_mode = 0;
    endcase
    if (m_mode != 1) m_hit = 0;
    m_fresh_q = fresh;
    m_start_q = START;
    m_pass_q  = score_out;
  endtask

  task automatic tick();
    logic [25:0] exp;
    model_step();
    @(posedge clk);
    #1;
    exp = {1'(m_mode == 1), 1'(m_mode == 3), to_bcd(m_score), to_bcd(m_best)};
    chk("cycle", {game_status, game_over, score, best}, exp);
  endtask

  task automatic idle_inputs();
    START = 0; fresh = 0; y = 0; is_bird = 0;
    is_column_up = 0; is_column_down = 0; score_out = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1; tick(); tick();
    RESET = 0; tick();
  endtask

  task automatic press_start();
    START = 1; tick();
    START = 0; tick();
  endtask

  task automatic pass_pipe(input int n);
    for (int i = 0; i < n; i++) begin
      score_out = 1; tick();
      score_out = 0; tick();
    end
  endtask

  task automatic frame_ends(input int n);
    for (int i = 0; i < n; i++) begin
      fresh = 1; tick();
      fresh = 0; tick();
    end
  endtask

  task automatic hit_frame();
    fresh = 1; tick();
    is_bird = 1; is_column_down = 1; tick();
    is_bird = 0; is_column_down = 0; fresh = 0; tick();
  endtask

  initial begin
    RESET = 1;
    idle_inputs();
    do_reset();
    chk("reset", {game_status, game_over, score, best}, 26'd0);

    // first game: three passes then a pipe hit
    press_start();
    pass_pipe(3);
    chk("play_status", game_status, 1);
    chk("score_3", score, 12'h003);
    chk("not_over", game_over, 0);
    fresh = 1; tick();
    is_bird = 1; is_column_up = 1; tick();
    is_bird = 0; is_column_up = 0; tick();
    chk("pre_hit_status", game_status, 1);
    fresh = 0; tick();
    chk("hit_status", game_status, 0);
    frame_ends(29);
    chk("dying_29", game_over, 0);
    frame_ends(1);
    chk("dying_30", game_over, 1);
    chk("best_3", best, 12'h003);

    // ground boundary
    press_start();
    press_start();
    is_bird = 1; y = 9'd424;
    fresh = 1; repeat (4) tick();
    fresh = 0; tick();
    chk("y424_no_hit", game_status, 1);
    fresh = 1; tick();
    y = 9'd425; tick();
    is_bird = 0; y = 0; fresh = 0; tick();
    chk("y425_hit", game_status, 0);
    frame_ends(30);
    chk("best_kept", best, 12'h003);

    // BCD carries and saturation
    press_start();
    press_start();
    pass_pipe(99);
    chk("score_099", score, 12'h099);
    pass_pipe(1);
    chk("score_100", score, 12'h100);
    pass_pipe(899);
    chk("score_999", score, 12'h999);
    pass_pipe(5);
    chk("score_sat", score, 12'h999);

    // simultaneous hit, pass and frame_end; best across two games
    do_reset();
    press_start();
    pass_pipe(4);
    fresh = 1; tick();
    fresh = 0; is_bird = 1; is_column_up = 1; score_out = 1; tick();
    chk("same_cycle_score", score, 12'h005);
    chk("same_cycle_dying", game_status, 0);
    is_bird = 0; is_column_up = 0; score_out = 0; tick();
    pass_pipe(1);
    chk("dying_pass", score, 12'h005);
    frame_ends(30);
    chk("best_game1", best, 12'h005);

    START = 1; repeat (6) tick();
    chk("held_start", {game_status, game_over}, 2'b00);
    START = 0; tick();
    START = 1; tick();
    chk("repress", game_status, 1);
    START = 0; tick();
    pass_pipe(3);
    hit_frame();
    frame_ends(30);
    chk("score_game2", score, 12'h003);
    chk("best_game2", best, 12'h005);

    // reset during dying
    press_start();
    press_start();
    pass_pipe(2);
    hit_frame();
    frame_ends(5);
    do_reset();
    chk("reset_dying", {game_status, game_over, score, best}, 26'd0);

    // randomized frames
    for (int f = 0; f < 400; f++) begin
      int lines;
      lines = int'($urandom_range(3, 8));
      for (int l = 0; l < lines + 2; l++) begin
        fresh          = (l < lines);
        RESET          = ($urandom % 500 == 0);
        START          = ($urandom % 12 == 0);
        score_out      = ($urandom % 3 == 0);
        is_bird        = ($urandom % 16 == 0);
        is_column_up   = ($urandom % 16 == 0);
        is_column_down = ($urandom % 16 == 0);
        y              = 9'($urandom_range(0, 430));
        tick();
      end
    end
    RESET = 0;
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_score.md
Name: collision_score

Overview:
- Consumer end of the pipe generator's pixel-flag interface.
- Each pixel clock, compares the generator's is_column_up/is_column_down flags and score_out level against the bird sprite flag and the ground line.
- Owns the game state machine that drives game_status back into the pipe generator, the 3-digit BCD score, and the best score.
- Sits between the pixel pipeline (pipe generator, bird sprite) and the score display / top-level game control.

Parameters:
- GROUND_Y, 425, first y row of ground; a bird pixel at y >= GROUND_Y is a hit.
- DYING_FRAMES, 30, frames spent in DYING before OVER (1..2^CNT_W-1).
- CNT_W, 5, width of the dying-frame counter.

Ports:
- clk  in  1  pixel clock, the same clock that registers the column flags; sole clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  player button, level; only its rising edge is used.
- fresh  in  1  frame strobe; its falling edge marks the start of blanking.
- y  in  9  current pixel row, aligned with the flag inputs.
- is_bird  in  1  bird sprite pixel flag, registered with the same latency as the column flags.
- is_column_up  in  1  lower-pipe pixel flag.
- is_column_down  in  1  upper-pipe pixel flag.
- score_out  in  1  pipe-passing level from the pipe generator.
- game_status  out  1  high only in PLAY; feeds the pipe generator.
- game_over  out  1  high only in OVER.
- score  out  12  BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
- best  out  12  BCD best score since RESET.

Behaviour:
- Everything runs on posedge clk. RESET has priority over all other logic.
- RESET values: state=IDLE, game_status=0, game_over=0, score=0, best=0, hit latch=0, dying counter=0, edge registers=0.
- Edge detectors (registered copies of fresh, START, score_out):
  - frame_end = fresh_q & ~fresh.
  - start_rise = START & ~start_q.
  - pass_rise = score_out & ~pass_q.
- Hit latch:
  - Sets in PLAY when is_bird & (is_column_up | is_column_down), or when is_bird & (y >= GROUND_Y).
  - Clears on every frame_end, after being sampled. A hit on the same cycle as frame_end still counts for that frame.
  - Ignored in every state other than PLAY.
- FSM (outputs are registered and follow the state one cycle after the transition):
  - IDLE: start_rise -> PLAY. On this transition score clears to 0.
  - PLAY: frame_end with hit latched (or hit on that cycle) -> DYING, dying counter loaded to 0.
  - DYING: the counter increments on each frame_end. On the frame_end where counter == DYING_FRAMES-1 -> OVER.
  - OVER: start_rise -> IDLE. START held high across transitions does not retrigger.
  - Entering OVER: if score > best (BCD compare, equivalent to binary compare digit by digit from the hundreds digit) then best <= score, on the same cycle as game_over rises.
- Scoring:
  - pass_rise in PLAY increments score as BCD: units wrap 9->0 with carry to tens, tens 9->0 with carry to hundreds.
  - Saturates at 999: no wrap, no change.
  - pass_rise on the same cycle as the PLAY->DYING transition still increments.
  - pass_rise outside PLAY is ignored.
- Latency: game_status falls on the cycle after the hit frame_end, so the pipe generator freezes on its next fresh falling edge.
- RESET mid-frame or mid-DYING: immediate return to IDLE; best is also cleared.

Test Plan:
- RESET, then START pulse, then 3 score_out 0->1->0 cycles -> game_status=1, score=12'h003, game_over=0.
- In PLAY, assert is_bird & is_column_up for 1 clk mid-frame, then fresh 1->0 -> game_status=0 on the next clk. After exactly 30 further frame_ends, game_over=1 and best=score.
- is_bird=1 at y=424 for a whole frame -> no hit; is_bird=1 at y=425 -> DYING at that frame_end.
- Preload score 099 via 99 passes, then 1 pass -> score=12'h100. Drive 999 + 5 passes -> score stays 12'h999.
- Hit and pass_rise on the same cycle as frame_end -> score increments and state goes to DYING. A pass during DYING -> no change.
- Game 1 ends with score 5, game 2 with score 3 -> best=12'h005. Hold START high through OVER->IDLE -> no PLAY until START is released and re-pressed. RESET during DYING -> IDLE, score=best=0.
